// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//
// Decode stage sitting directly in front of alu_top. Fetch hands over 32-bit
// MIPS instruction words on a valid/ready handshake; each word is decoded into
// the ALU operation code (1..12), register indices and second operand, then
// held in a 2-entry FIFO so that ALU backpressure never reaches fetch
// combinationally. Saturating debug counters track accepted and illegal words.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   in_valid     in   fetch presents in_ir this cycle
//   in_ready     out  stage can accept a word (registered, from occupancy only)
//   in_ir        in   32-bit instruction word
//   out_valid    out  head entry holds a decoded instruction
//   out_ready    in   ALU consumes the head entry this cycle
//   out_ir       out  original instruction word
//   out_instr_ID out  ALU operation code, 0 = nop/illegal
//   out_rs       out  ir[25:21]
//   out_rt       out  ir[20:16]
//   out_rd       out  destination register (ir[15:11] R-type, ir[20:16] I-type)
//   out_opb      out  second operand: extended immediate or shamt, else 0
//   out_use_imm  out  ALU takes out_opb instead of reg[rt]
//   out_illegal  out  word is not a supported instruction (and not a nop)
//   dec_count    out  saturating count of accepted words
//   ill_count    out  saturating count of accepted illegal words
// ---------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic [31:0]      out_instr_ID,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_opb,
  output logic             out_use_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  // One decoded FIFO entry. The operation code only needs 4 bits internally;
  // it is zero-extended to the 32-bit ALU dispatch field on the way out.
  typedef struct packed {
    logic [31:0] ir;
    logic [3:0]  id;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] opb;
    logic        useImm;
    logic        illegal;
  } entry_t;

  // Pure decode of one instruction word. The all-zero word is tested first
  // because it would otherwise match sll $0,$0,0.
  function automatic entry_t decodeWord(input logic [31:0] ir);
    entry_t e;
    e        = '0;
    e.ir     = ir;
    e.rs     = ir[25:21];
    e.rt     = ir[20:16];
    e.rd     = ir[15:11];
    if (ir != 32'h0) begin
      case (ir[31:26])
        6'h00: begin
          case (ir[5:0])
            6'h20: e.id = 4'd1;
            6'h22: e.id = 4'd2;
            6'h21: e.id = 4'd3;
            6'h23: e.id = 4'd4;
            6'h24: e.id = 4'd7;
            6'h25: e.id = 4'd8;
            6'h00: begin
              e.id     = 4'd11;
              e.opb    = {27'b0, ir[10:6]};
              e.useImm = 1'b1;
            end
            6'h02: begin
              e.id     = 4'd12;
              e.opb    = {27'b0, ir[10:6]};
              e.useImm = 1'b1;
            end
            default: e.illegal = 1'b1;
          endcase
        end
        6'h08, 6'h09: begin
          e.id     = (ir[31:26] == 6'h08) ? 4'd5 : 4'd6;
          e.rd     = ir[20:16];
          e.opb    = {{16{ir[15]}}, ir[15:0]};
          e.useImm = 1'b1;
        end
        6'h0C, 6'h0D: begin
          e.id     = (ir[31:26] == 6'h0C) ? 4'd9 : 4'd10;
          e.rd     = ir[20:16];
          e.opb    = {16'b0, ir[15:0]};
          e.useImm = 1'b1;
        end
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           newEntry;
  logic [1:0]       occ_q, occ_d;
  logic             inReady_q;
  logic [CNT_W-1:0] decCount_q, decCount_d;
  logic [CNT_W-1:0] illCount_q, illCount_d;
  logic             accept;
  logic             consume;

  // Next-state for the 2-entry FIFO. With one entry and a simultaneous
  // accept/consume the new word goes straight into the head, so order holds
  // and occupancy stays at one. A full FIFO can never accept because
  // in_ready is low, so the occupancy-2 case only handles the drain.
  always_comb begin
    newEntry   = decodeWord(in_ir);
    accept     = in_valid & inReady_q;
    consume    = (occ_q != 2'd0) & out_ready;
    head_d     = head_q;
    skid_d     = skid_q;
    occ_d      = occ_q;
    decCount_d = decCount_q;
    illCount_d = illCount_q;

    case (occ_q)
      2'd0: begin
        if (accept) begin
          head_d = newEntry;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (accept && consume) begin
          head_d = newEntry;
        end else if (accept) begin
          skid_d = newEntry;
          occ_d  = 2'd2;
        end else if (consume) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        if (consume) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end
      end
    endcase

    // Counters stick at all-ones rather than wrapping.
    if (accept && (decCount_q != '1)) begin
      decCount_d = decCount_q + 1'b1;
    end
    if (accept && newEntry.illegal && (illCount_q != '1)) begin
      illCount_d = illCount_q + 1'b1;
    end
  end

  // State registers. in_ready is registered from the next occupancy so it
  // stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      inReady_q  <= 1'b0;
      decCount_q <= '0;
      illCount_q <= '0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      occ_q      <= occ_d;
      inReady_q  <= (occ_d != 2'd2);
      decCount_q <= decCount_d;
      illCount_q <= illCount_d;
    end
  end

  assign in_ready     = inReady_q;
  assign out_valid    = (occ_q != 2'd0);
  assign out_ir       = head_q.ir;
  assign out_instr_ID = {28'b0, head_q.id};
  assign out_rs       = head_q.rs;
  assign out_rt       = head_q.rt;
  assign out_rd       = head_q.rd;
  assign out_opb      = head_q.opb;
  assign out_use_imm  = head_q.useImm;
  assign out_illegal  = head_q.illegal;
  assign dec_count    = decCount_q;
  assign ill_count    = illCount_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Directed bench for instr_decode_stage. Each feature has its own task that
// drives vectors and compares the DUT against hand-computed values. Inputs
// are driven and outputs sampled 1 ns after the rising edge. The counters
// are narrowed to 8 bits so saturation is reachable in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ir;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_ir;
  logic [31:0]      out_instr_ID;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [31:0]      out_opb;
  logic             out_use_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] dec_count;
  logic [CNT_W-1:0] ill_count;

  int errors;
  int checks;
  int expDec;
  int expIll;

  instr_decode_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ir        (in_ir),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ir       (out_ir),
    .out_instr_ID (out_instr_ID),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_opb      (out_opb),
    .out_use_imm  (out_use_imm),
    .out_illegal  (out_illegal),
    .dec_count    (dec_count),
    .ill_count    (ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single edge with the FIFO able to accept it.
  task automatic sendOne(input logic [31:0] word);
    in_valid = 1'b1;
    in_ir    = word;
    tick();
    in_valid = 1'b0;
  endtask

  // Full decoded view of the head entry, used for whole-entry comparisons.
  function automatic logic [113:0] headView();
    return {out_valid, out_ir, out_instr_ID, out_rs, out_rt, out_rd,
            out_opb, out_use_imm, out_illegal};
  endfunction

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({out_valid, in_ready, dec_count, ill_count} !== {1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
      $display("[TB] FAIL reset_state: valid/ready/dec/ill got %b/%b/%0d/%0d expected 0/0/0/0",
               out_valid, in_ready, dec_count, ill_count);
      errors++;
    end
    checks++;
    if (headView() !== 114'd0) begin
      $display("[TB] FAIL reset_fields: got %h expected 0", headView());
      errors++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("[TB] FAIL reset_release: ready/valid got %b%b expected 10", in_ready, out_valid);
      errors++;
    end
    expDec = 0;
    expIll = 0;
  endtask

  task automatic test_rtype();
    logic [113:0] exp;
    out_ready = 1'b1;
    sendOne(32'h012A4020);
    expDec++;
    exp = {1'b1, 32'h012A4020, 32'd1, 5'd9, 5'd10, 5'd8, 32'd0, 1'b0, 1'b0};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL add_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    checks++;
    if (dec_count !== CNT_W'(expDec)) begin
      $display("[TB] FAIL add_count: got %0d expected %0d", dec_count, expDec);
      errors++;
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL add_consumed: out_valid got %b expected 0", out_valid);
      errors++;
    end
  endtask

  task automatic test_itype();
    logic [113:0] exp;
    out_ready = 1'b1;
    sendOne(32'h2128FFFF);
    expDec++;
    exp = {1'b1, 32'h2128FFFF, 32'd5, 5'd9, 5'd8, 5'd8, 32'hFFFFFFFF, 1'b1, 1'b0};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL addi_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    tick();
    sendOne(32'h3528FFFF);
    expDec++;
    exp = {1'b1, 32'h3528FFFF, 32'd10, 5'd9, 5'd8, 5'd8, 32'h0000FFFF, 1'b1, 1'b0};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL ori_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    tick();
  endtask

  task automatic test_shift();
    logic [113:0] exp;
    out_ready = 1'b1;
    sendOne(32'h000A4080);
    expDec++;
    exp = {1'b1, 32'h000A4080, 32'd11, 5'd0, 5'd10, 5'd8, 32'd2, 1'b1, 1'b0};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL sll_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    tick();
    sendOne(32'h000A4082);
    expDec++;
    exp = {1'b1, 32'h000A4082, 32'd12, 5'd0, 5'd10, 5'd8, 32'd2, 1'b1, 1'b0};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL srl_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    tick();
  endtask

  task automatic test_illegal_nop();
    logic [113:0] exp;
    out_ready = 1'b1;
    sendOne(32'hFC000000);
    expDec++;
    expIll++;
    exp = {1'b1, 32'hFC000000, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL illegal_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    checks++;
    if (ill_count !== CNT_W'(expIll)) begin
      $display("[TB] FAIL illegal_count: got %0d expected %0d", ill_count, expIll);
      errors++;
    end
    tick();
    sendOne(32'h00000000);
    expDec++;
    exp = {1'b1, 32'h0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0};
    checks++;
    if (headView() !== exp) begin
      $display("[TB] FAIL nop_decode: got %h expected %h", headView(), exp);
      errors++;
    end
    checks++;
    if ({dec_count, ill_count} !== {CNT_W'(expDec), CNT_W'(expIll)}) begin
      $display("[TB] FAIL nop_counts: dec/ill got %0d/%0d expected %0d/%0d",
               dec_count, ill_count, expDec, expIll);
      errors++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [31:0] ids   [4];
    words = '{32'h012A4020, 32'h01495022, 32'h3128000F, 32'h25280010};
    ids   = '{32'd1, 32'd2, 32'd9, 32'd6};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ir = words[i];
      tick();
      expDec++;
      checks++;
      if ({out_valid, in_ready, out_ir, out_instr_ID} !== {1'b1, 1'b1, words[i], ids[i]}) begin
        $display("[TB] FAIL b2b_word%0d: valid/ready/ir/id got %b/%b/%h/%0d expected 1/1/%h/%0d",
                 i, out_valid, in_ready, out_ir, out_instr_ID, words[i], ids[i]);
        errors++;
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL b2b_drain: out_valid got %b expected 0", out_valid);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 32'h012A4020;
    tick();
    in_ir     = 32'h2128FFFF;
    tick();
    in_ir     = 32'h000A4080;
    expDec += 2;
    checks++;
    if ({in_ready, out_valid, out_ir} !== {1'b0, 1'b1, 32'h012A4020}) begin
      $display("[TB] FAIL bp_full: ready/valid/ir got %b/%b/%h expected 0/1/012a4020",
               in_ready, out_valid, out_ir);
      errors++;
    end
    repeat (3) tick();
    checks++;
    if ({in_ready, out_ir, dec_count} !== {1'b0, 32'h012A4020, CNT_W'(expDec)}) begin
      $display("[TB] FAIL bp_hold: ready/ir/dec got %b/%h/%0d expected 0/012a4020/%0d",
               in_ready, out_ir, dec_count, expDec);
      errors++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_ir} !== {1'b1, 1'b1, 32'h2128FFFF}) begin
      $display("[TB] FAIL bp_pop: ready/valid/ir got %b/%b/%h expected 1/1/2128ffff",
               in_ready, out_valid, out_ir);
      errors++;
    end
    tick();
    in_valid = 1'b0;
    expDec++;
    checks++;
    if ({in_ready, out_ir, dec_count} !== {1'b0, 32'h2128FFFF, CNT_W'(expDec)}) begin
      $display("[TB] FAIL bp_third: ready/ir/dec got %b/%h/%0d expected 0/2128ffff/%0d",
               in_ready, out_ir, dec_count, expDec);
      errors++;
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_ir} !== {1'b1, 32'h000A4080}) begin
      $display("[TB] FAIL bp_order: valid/ir got %b/%h expected 1/000a4080", out_valid, out_ir);
      errors++;
    end
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("[TB] FAIL bp_empty: valid/ready got %b%b expected 01", out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_saturation();
    int n;
    n = (1 << CNT_W) + 3;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ir     = 32'hFC000000;
    repeat (n) tick();
    in_valid = 1'b0;
    expDec = (expDec + n > CNT_MAX) ? CNT_MAX : expDec + n;
    expIll = (expIll + n > CNT_MAX) ? CNT_MAX : expIll + n;
    checks++;
    if (dec_count !== CNT_W'(expDec)) begin
      $display("[TB] FAIL sat_dec: got %0d expected %0d", dec_count, expDec);
      errors++;
    end
    checks++;
    if (ill_count !== CNT_W'(expIll)) begin
      $display("[TB] FAIL sat_ill: got %0d expected %0d", ill_count, expIll);
      errors++;
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [113:0] exp;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ir     = 32'h012A4020;
    tick();
    in_ir     = 32'h3528FFFF;
    tick();
    in_valid  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, dec_count, ill_count, out_ir} !==
        {1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}, 32'h0}) begin
      $display("[TB] FAIL midreset: valid/ready/dec/ill/ir got %b/%b/%0d/%0d/%h expected 0/0/0/0/0",
               out_valid, in_ready, dec_count, ill_count, out_ir);
      errors++;
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("[TB] FAIL midreset_release: ready/valid got %b%b expected 10", in_ready, out_valid);
      errors++;
    end
    out_ready = 1'b1;
    sendOne(32'h2128FFFF);
    exp = {1'b1, 32'h2128FFFF, 32'd5, 5'd9, 5'd8, 5'd8, 32'hFFFFFFFF, 1'b1, 1'b0};
    checks++;
    if ({headView(), dec_count} !== {exp, CNT_W'(1)}) begin
      $display("[TB] FAIL midreset_restart: got %h/%0d expected %h/1", headView(), dec_count, exp);
      errors++;
    end
    tick();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    expDec    = 0;
    expIll    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_ir     = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_shift();
    test_illegal_nop();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
